// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result handshake bundle for the bit-serial adder.
//   master : upstream initiator. It drives in_valid, a, b, sub and out_ready.
//   slave  : addsub_serial. It drives in_ready, out_valid, result, cout and overflow.
//
// Handshake rule: a transfer happens on a rising clk edge where valid && ready.
// The valid side holds its payload until that edge. The ready side may
// change ready freely. Neither ready depends combinationally on the other
// side's valid.
interface addsub_serial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: bit-serial adder/subtractor. It computes a+b or a-b one bit
// per cycle, LSB first, over WIDTH cycles.
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   bus       : addsub_serial_if slave. Operands are accepted on in_valid/in_ready.
//               result, cout and overflow are returned on out_valid/out_ready.
//   dbg_state : current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//
// Subtraction is performed as a + ~b + 1. When sub is set, the inverted b is
// latched and the carry starts at 1. cout = 0 therefore means a borrow occurred.
module addsub_serial #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  addsub_serial_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic sum_bit;
  logic carry_next;

  // Full adder on the current LSBs.
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = SHIFT;
      SHIFT:   if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state only. No input reaches a ready or valid output combinationally.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    dbg_state     = state;
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // The visible outputs update only on this edge, which enters DONE.
            // On the MSB, carry is the carry into the MSB. Signed overflow is
            // that carry XOR the carry out of the MSB.
            result_q <= {sum_bit, res_sr[WIDTH-1:1]};
            cout_q   <= carry_next;
            ovf_q    <= carry ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;
  localparam int W  = 4;
  localparam int PW = W + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  addsub_serial_if #(.WIDTH(W)) bus ();

  addsub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {cout, overflow, result}. It uses plain integer arithmetic:
  // unsigned sum for the carry and signed range test for overflow.
  function automatic logic [PW-1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                          input logic isub);
    int ua, ub, full, sa, sb, sr;
    logic co, ov;
    logic [W-1:0] r;
    ua   = int'(ia);
    ub   = int'(ib);
    full = isub ? (ua + ((1 << W) - 1 - ub) + 1) : (ua + ub);
    r    = W'(full % (1 << W));
    co   = (full >= (1 << W));
    sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sr   = isub ? (sa - sb) : (sa + sb);
    ov   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {co, ov, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Runs one operation with out_ready high. Operands are scrambled right after
  // acceptance. The task returns the observed outputs and the latency in cycles
  // after the acceptance edge, or -1 on timeout. It ends #1 after the handshake edge.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        output logic [PW-1:0] obs, output int lat);
    int waited;
    @(negedge clk);
    bus.a         = ia;
    bus.b         = ib;
    bus.sub       = isub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.sub      = 1'($urandom_range(0, 1));
    lat = -1;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    obs = {bus.cout, bus.overflow, bus.result};
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.overflow} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b result=%0d cout=%b ovf=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{4'd10, 4'd11, 4'd8, 4'd2, 4'd15};
    logic [W-1:0] tb [5] = '{4'd10, 4'd9,  4'd2, 4'd14, 4'd0};
    logic         ts [5] = '{1'b0,  1'b1,  1'b1, 1'b1,  1'b0};
    logic [PW-1:0] obs, exp;
    int lat;
    for (int k = 0; k < 5; k++) begin
      exp = model(ta[k], tb[k], ts[k]);
      run_op(ta[k], tb[k], ts[k], obs, lat);
      checks++;
      if (lat !== W) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", k, lat, W);
      end
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL directed_result[%0d]: a=%0d b=%0d sub=%b got {cout,ovf,res}=%b required %b",
                 k, ta[k], tb[k], ts[k], obs, exp);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed_after_hs[%0d]: in_ready=%b out_valid=%b required 1 0",
                 k, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    logic rs;
    logic [PW-1:0] obs, exp;
    int lat;
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rs));
      run_op(ra, rb, rs, obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== W || obs !== exp) begin
        failures++;
        $display("FAIL random_op[%0d]: a=%0d b=%0d sub=%b lat=%0d got %b required lat=%0d %b",
                 k, ra, rb, rs, lat, obs, W, exp);
      end
    end
  endtask

  task automatic test_operand_change();
    // run_op scrambles a/b/sub right after acceptance. This walks the extreme operands.
    logic [PW-1:0] obs, exp;
    int lat;
    for (int k = 0; k < 4; k++) begin
      exp = model(W'(k[1] ? 0 : (1 << W) - 1), W'(k[0] ? 0 : (1 << W) - 1), k[0] ^ k[1]);
      run_op(W'(k[1] ? 0 : (1 << W) - 1), W'(k[0] ? 0 : (1 << W) - 1), k[0] ^ k[1], obs, lat);
      checks++;
      if (obs !== exp || lat !== W) begin
        failures++;
        $display("FAIL operand_change[%0d]: got %b lat=%0d required %b lat=%0d", k, obs, lat, exp, W);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp, obs;
    logic [1:0] st0;
    int lat, waited;
    exp = model(4'd7, 4'd5, 1'b0);
    @(negedge clk);
    bus.a = 4'd7; bus.b = 4'd5; bus.sub = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== W || {bus.cout, bus.overflow, bus.result} !== exp) begin
      failures++;
      $display("FAIL bp_first: lat=%0d got %b required lat=%0d %b",
               lat, {bus.cout, bus.overflow, bus.result}, W, exp);
    end
    st0 = dbg_state;
    // A competing request during DONE must be ignored.
    bus.in_valid = 1'b1;
    bus.a = 4'd3; bus.b = 4'd12; bus.sub = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.cout, bus.overflow, bus.result} !== exp || dbg_state !== st0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%b state=%0d required 1 0 %b %0d",
                 c, bus.out_valid, bus.in_ready, {bus.cout, bus.overflow, bus.result}, dbg_state, exp, st0);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    exp = model(4'd3, 4'd12, 1'b1);
    run_op(4'd3, 4'd12, 1'b1, obs, lat);
    checks++;
    if (obs !== exp || lat !== W) begin
      failures++;
      $display("FAIL bp_next_op: got %b lat=%0d required %b lat=%0d", obs, lat, exp, W);
    end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] exp, obs;
    int lat;
    bit seen;
    @(negedge clk);
    bus.a = 4'd9; bus.b = 4'd6; bus.sub = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.overflow} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_values: in_ready=%b out_valid=%b result=%0d cout=%b ovf=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_discard: out_valid_seen=%b in_ready=%b required 0 1", seen, bus.in_ready);
    end
    exp = model(4'd5, 4'd13, 1'b1);
    run_op(4'd5, 4'd13, 1'b1, obs, lat);
    checks++;
    if (obs !== exp || lat !== W) begin
      failures++;
      $display("FAIL reset_mid_next_op: got %b lat=%0d required %b lat=%0d", obs, lat, exp, W);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_operand_change();
    test_backpressure();
    test_reset_mid();
    apply_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
